mostrador_scan: RTL and testbench

Time-multiplexed 7-segment display driver. It sits directly downstream of the mostrador segment decoders and consumes their SEGA..SEGG outputs, one 7-bit word per digit. It scans N_DIG common-anode/cathode digits, driving one shared segment bus plus per-digit enables. A dead-time gap between digits suppresses ghosting.

---
 rtl/mostrador_scan.sv | 133 +++++++++++++
 tb/tb_mostrador_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mostrador_scan.sv
// Time-multiplexed 7-segment scan driver: one shared segment bus, per-digit enables,
// with a dead-time gap between digit slots to suppress ghosting.
module mostrador_scan #(
    parameter int N_DIG          = 4,
    parameter int DWELL          = 50000,
    parameter int GAP            = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7*N_DIG-1:0] seg_in,
    input  logic               load,
    input  logic [N_DIG-1:0]   blank_mask,
    output logic [6:0]         seg_out,
    output logic [N_DIG-1:0]   dig_out,
    output logic               frame
);

    localparam int CNT_MAX0 = (DWELL > GAP) ? DWELL : GAP;
    localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
    localparam int CNT_W    = $clog2(CNT_MAX);
    localparam int IDX_W    = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);

    localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIG-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

    localparam logic [0:0] ST_GAP  = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    function automatic logic [6:0] seg_drive(input logic [6:0] segs);
        return SEG_ACTIVE_LOW ? ~segs : segs;
    endfunction

    function automatic logic [N_DIG-1:0] dig_drive(input logic [IDX_W-1:0] idx);
        logic [N_DIG-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return DIG_ACTIVE_LOW ? ~oh : oh;
    endfunction

    logic [0:0]                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [N_DIG-1:0][6:0]      shadow_q, shadow_d;
    logic [6:0]                 seg_q, seg_d;
    logic [N_DIG-1:0]           dig_q, dig_d;
    logic                       frame_q, frame_d;

    logic                       enter;
    logic [IDX_W-1:0]           show_idx;
    logic [IDX_W-1:0]           idx_nxt;

    assign idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        seg_d    = seg_q;
        dig_d    = dig_q;
        frame_d  = 1'b0;
        shadow_d = load ? seg_in : shadow_q;
        enter    = 1'b0;
        show_idx = idx_q;

        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    enter = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    idx_d = idx_nxt;
                    // Without a gap the next slot starts on this same edge.
                    if (GAP == 0) begin
                        enter    = 1'b1;
                        show_idx = idx_nxt;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                        seg_d   = SEG_OFF;
                        dig_d   = DIG_OFF;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_GAP;
        endcase

        // Slot entry reads the pre-edge shadow, so a coincident load waits a full scan.
        if (enter) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            seg_d   = seg_drive(shadow_q[show_idx]);
            dig_d   = blank_mask[show_idx] ? DIG_OFF : dig_drive(show_idx);
            frame_d = (show_idx == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_GAP;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            dig_q    <= DIG_OFF;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            frame_q  <= frame_d;
        end
    end

    assign seg_out = seg_q;
    assign dig_out = dig_q;
    assign frame   = frame_q;

endmodule

// File: tb/tb_mostrador_scan.sv
// Bench for mostrador_scan: a gapped build (DWELL=4, GAP=2) and a gapless build
// (DWELL=3, GAP=0) share stimulus and are checked every cycle against a slot-arithmetic model.
module tb_mostrador_scan;

    logic        clk;
    logic        rst;
    logic [27:0] seg_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;
    logic        frame_a, frame_b;

    int checks;
    int errors;

    mostrador_scan #(.N_DIG(4), .DWELL(4), .GAP(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .seg_in(seg_in), .load(load), .blank_mask(blank_mask),
        .seg_out(seg_a), .dig_out(dig_a), .frame(frame_a)
    );

    mostrador_scan #(.N_DIG(4), .DWELL(3), .GAP(0), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .seg_in(seg_in), .load(load), .blank_mask(blank_mask),
        .seg_out(seg_b), .dig_out(dig_b), .frame(frame_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per build: edges since reset release, shadow copy, expected outputs.
    int         p_dwell [2] = '{4, 3};
    int         p_gap   [2] = '{2, 0};
    int         mn      [2];
    logic [6:0] msh     [2][4];
    logic [6:0] mseg    [2];
    logic [3:0] mdig    [2];
    logic       mfr     [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int k, input logic r, input logic ld,
                              input logic [27:0] s, input logic [3:0] bm);
        int first, p, off, j, d;
        if (r) begin
            mn[k] = 0;
            for (int i = 0; i < 4; i++) msh[k][i] = 7'h00;
            mseg[k] = 7'h7F;
            mdig[k] = 4'hF;
            mfr[k]  = 1'b0;
        end else begin
            mn[k]++;
            first  = (p_gap[k] > 1) ? p_gap[k] : 1;
            p      = p_dwell[k] + p_gap[k];
            mfr[k] = 1'b0;
            if (mn[k] >= first) begin
                off = (mn[k] - first) % p;
                j   = (mn[k] - first) / p;
                d   = j % 4;
                if (off == 0) begin
                    mseg[k] = ~msh[k][d];
                    mdig[k] = bm[d] ? 4'hF : ~(4'b0001 << d);
                    mfr[k]  = (d == 0);
                end else if (off >= p_dwell[k]) begin
                    mseg[k] = 7'h7F;
                    mdig[k] = 4'hF;
                end
            end else begin
                mseg[k] = 7'h7F;
                mdig[k] = 4'hF;
            end
            if (ld) begin
                for (int i = 0; i < 4; i++) msh[k][i] = s[7*i +: 7];
            end
        end
    endtask

    task automatic tick(input logic r, input logic ld, input logic [27:0] s, input logic [3:0] bm);
        rst        = r;
        load       = ld;
        seg_in     = s;
        blank_mask = bm;
        @(posedge clk);
        model_edge(0, r, ld, s, bm);
        model_edge(1, r, ld, s, bm);
        #1;
        chk("seg_a",   32'(seg_a),   32'(mseg[0]));
        chk("dig_a",   32'(dig_a),   32'(mdig[0]));
        chk("frame_a", 32'(frame_a), 32'(mfr[0]));
        chk("seg_b",   32'(seg_b),   32'(mseg[1]));
        chk("dig_b",   32'(dig_b),   32'(mdig[1]));
        chk("frame_b", 32'(frame_b), 32'(mfr[1]));
    endtask

    task automatic lit_a(input string nm, input logic [3:0] d, input logic [6:0] s, input logic f);
        chk({nm, "_dig"},   32'(dig_a),   32'(d));
        chk({nm, "_seg"},   32'(seg_a),   32'(s));
        chk({nm, "_frame"}, 32'(frame_a), 32'(f));
    endtask

    logic [27:0] w1, w2, cur;

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0; mseg[k] = 7'h7F; mdig[k] = 4'hF; mfr[k] = 1'b0;
            for (int i = 0; i < 4; i++) msh[k][i] = 7'h00;
        end
        rst = 1'b1; load = 1'b0; seg_in = '0; blank_mask = '0;
        w1 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        w2 = {7'h4F, 7'h5B, 7'h66, 7'h3F};

        repeat (3) begin
            tick(1'b1, 1'b0, '0, 4'h0);
            lit_a("reset", 4'hF, 7'h7F, 1'b0);
        end

        tick(1'b0, 1'b1, w1, 4'h0);
        lit_a("gap1", 4'hF, 7'h7F, 1'b0);
        chk("b_first_dig",   32'(dig_b),   32'h0000000E);
        chk("b_first_seg",   32'(seg_b),   32'h0000007F);
        chk("b_first_frame", 32'(frame_b), 32'h1);
        tick(1'b0, 1'b0, w1, 4'h0);
        lit_a("d0_first", 4'b1110, 7'h40, 1'b1);

        cur = w1;
        for (int n = 3; n <= 62; n++) begin
            if (n == 10) cur = w2;
            tick(1'b0, (n == 10), cur, (n >= 33 && n <= 45) ? 4'b0100 : 4'b0000);
            case (n)
                3:  lit_a("d0_hold",   4'b1110, 7'h40, 1'b0);
                4:  begin
                        chk("b_d1_dig", 32'(dig_b), 32'h0000000D);
                        chk("b_d1_seg", 32'(seg_b), 32'h00000079);
                    end
                6:  lit_a("gap_a",     4'hF,    7'h7F, 1'b0);
                7:  lit_a("gap_b",     4'hF,    7'h7F, 1'b0);
                8:  lit_a("d1",        4'b1101, 7'h79, 1'b0);
                10: lit_a("tear_load", 4'b1101, 7'h79, 1'b0);
                11: lit_a("tear_hold", 4'b1101, 7'h79, 1'b0);
                13: begin
                        chk("b_wrap_dig",   32'(dig_b),   32'h0000000E);
                        chk("b_wrap_frame", 32'(frame_b), 32'h1);
                    end
                14: lit_a("d2",        4'b1011, 7'h24, 1'b0);
                20: lit_a("d3",        4'b0111, 7'h30, 1'b0);
                26: lit_a("d0_scan2",  4'b1110, 7'h40, 1'b1);
                32: lit_a("tear_new",  4'b1101, 7'h19, 1'b0);
                38: chk("blank_d2", 32'(dig_a), 32'h0000000F);
                44: lit_a("after_blank", 4'b0111, 7'h30, 1'b0);
                50: lit_a("d0_scan3",  4'b1110, 7'h40, 1'b1);
                default: ;
            endcase
        end

        tick(1'b1, 1'b0, w2, 4'h0);
        lit_a("midrst", 4'hF, 7'h7F, 1'b0);
        tick(1'b0, 1'b0, w2, 4'h0);
        lit_a("midrst_gap", 4'hF, 7'h7F, 1'b0);
        tick(1'b0, 1'b0, w2, 4'h0);
        lit_a("midrst_d0", 4'b1110, 7'h7F, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0),
                 28'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
